gpio_serial_loader: RTL and testbench



---
 rtl/gpio_cfg_pkg.sv | 34 +++
 rtl/gpio_serial_phase.sv | 38 +++
 rtl/gpio_serial_loader.sv | 133 +++++++++++++
 tb/tb_gpio_serial_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// GPIO pad configuration word layout and serial loader state encoding.
// Shared by gpio_serial_loader and gpio_control_block.
package gpio_cfg_pkg;

    // Bits per pad configuration word
    localparam int CFG_BITS = 13;

    // Field bit positions inside one configuration word
    localparam int MGMT_ENA_BIT    = 0;
    localparam int OUTENB_BIT      = 1;
    localparam int HOLDOVER_BIT    = 2;
    localparam int INP_DIS_BIT     = 3;
    localparam int IB_MODE_SEL_BIT = 4;
    localparam int ANALOG_EN_BIT   = 5;
    localparam int ANALOG_SEL_BIT  = 6;
    localparam int ANALOG_POL_BIT  = 7;
    localparam int SLOW_SEL_BIT    = 8;
    localparam int VTRIP_SEL_BIT   = 9;
    localparam int DM_LSB          = 10;
    localparam int DM_MSB          = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_LOAD
    } loader_state_e;

    // Drive-mode field of a configuration word
    function automatic logic [2:0] cfg_dm(input logic [CFG_BITS-1:0] word);
        return word[DM_MSB:DM_LSB];
    endfunction

endpackage

// File: rtl/gpio_serial_phase.sv
// Serial clock phase generator: counts CLK_DIV core cycles per half-period.
// Ports: clock, resetb (async active-low), run (count enable, clears when low),
//        phase_end (last cycle of current phase), phase (0 = low, 1 = high half).
module gpio_serial_phase #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic run,
    output logic phase_end,
    output logic phase
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign phase_end = run && (div_cnt == LAST);

    // Held at the start of a low phase whenever the FSM is not shifting or
    // loading, so every SHIFT and LOAD begins with a full-length low phase.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts one configuration word per pad into the GPIO control chain, then loads.
// Ports: clock, resetb (async active-low), start; cfg_addr/cfg_data register-file
//        fetch; serial_clock/data/load/resetn chain drive; busy, done status.
module gpio_serial_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = gpio_cfg_pkg::CFG_BITS,
    parameter int CLK_DIV  = 2
) (
    input  logic                        clock,
    input  logic                        resetb,
    input  logic                        start,
    output logic [$clog2(NUM_PADS)-1:0] cfg_addr,
    input  logic [CFG_BITS-1:0]         cfg_data,
    output logic                        serial_clock,
    output logic                        serial_data,
    output logic                        serial_load,
    output logic                        serial_resetn,
    output logic                        busy,
    output logic                        done
);

    import gpio_cfg_pkg::*;

    localparam int PW = $clog2(NUM_PADS);
    localparam int BW = $clog2(CFG_BITS + 1);
    localparam logic [PW-1:0] LAST_PAD = PW'(NUM_PADS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);

    loader_state_e       state;
    logic [PW-1:0]       pad_idx;
    logic [BW-1:0]       bit_cnt;
    logic [CFG_BITS-1:0] sreg;
    logic                fetch_second;
    logic                run;
    logic                phase_end;
    logic                phase;

    assign run = (state == ST_SHIFT) || (state == ST_LOAD);

    gpio_serial_phase #(
        .CLK_DIV   (CLK_DIV)
    ) u_phase (
        .clock     (clock),
        .resetb    (resetb),
        .run       (run),
        .phase_end (phase_end),
        .phase     (phase)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state         <= ST_IDLE;
            pad_idx       <= '0;
            bit_cnt       <= '0;
            sreg          <= '0;
            fetch_second  <= 1'b0;
            cfg_addr      <= '0;
            serial_clock  <= 1'b0;
            serial_data   <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            serial_resetn <= 1'b1;
            done          <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Chain enters at pad 0, so the far pad goes first
                        pad_idx      <= LAST_PAD;
                        cfg_addr     <= LAST_PAD;
                        fetch_second <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // First cycle lets the register file see the new address
                    if (!fetch_second) begin
                        fetch_second <= 1'b1;
                    end else begin
                        sreg        <= cfg_data;
                        bit_cnt     <= '0;
                        serial_data <= cfg_data[CFG_BITS-1];
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (phase_end) begin
                        if (!phase) begin
                            serial_clock <= 1'b1;
                        end else begin
                            serial_clock <= 1'b0;
                            sreg         <= sreg << 1;
                            bit_cnt      <= bit_cnt + 1'b1;
                            // bit_cnt reaches CFG_BITS on this edge: word done
                            if (bit_cnt == LAST_BIT) begin
                                serial_data <= 1'b0;
                                if (pad_idx == '0) begin
                                    state <= ST_LOAD;
                                end else begin
                                    pad_idx      <= pad_idx - 1'b1;
                                    cfg_addr     <= pad_idx - 1'b1;
                                    fetch_second <= 1'b0;
                                    state        <= ST_FETCH;
                                end
                            end else begin
                                serial_data <= sreg[CFG_BITS-2];
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    // Low phase is setup after the last rising edge,
                    // high phase of the divider carries the load strobe.
                    if (phase_end) begin
                        if (!phase) begin
                            serial_load <= 1'b1;
                        end else begin
                            serial_load <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: default chain and a 2-pad, CLK_DIV=1 chain.
// Register files are modelled with one-cycle read latency and optional garbage.
module tb_gpio_serial_loader;

    logic clock;
    logic resetb;

    // Default instance
    logic        b_start;
    logic [5:0]  b_cfg_addr;
    logic [12:0] b_cfg_data;
    logic        b_sclk, b_sdat, b_sload, b_srstn, b_busy, b_done;

    // Small instance: NUM_PADS=2, CLK_DIV=1
    logic        s_start;
    logic [0:0]  s_cfg_addr;
    logic [12:0] s_cfg_data;
    logic        s_sclk, s_sdat, s_sload, s_srstn, s_busy, s_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] b_mem [0:37];
    logic [12:0] s_mem [0:1];
    logic        garbage = 1'b0;

    gpio_serial_loader u_dut (
        .clock         (clock),
        .resetb        (resetb),
        .start         (b_start),
        .cfg_addr      (b_cfg_addr),
        .cfg_data      (b_cfg_data),
        .serial_clock  (b_sclk),
        .serial_data   (b_sdat),
        .serial_load   (b_sload),
        .serial_resetn (b_srstn),
        .busy          (b_busy),
        .done          (b_done)
    );

    gpio_serial_loader #(
        .NUM_PADS (2),
        .CFG_BITS (13),
        .CLK_DIV  (1)
    ) u_small (
        .clock         (clock),
        .resetb        (resetb),
        .start         (s_start),
        .cfg_addr      (s_cfg_addr),
        .cfg_data      (s_cfg_data),
        .serial_clock  (s_sclk),
        .serial_data   (s_sdat),
        .serial_load   (s_sload),
        .serial_resetn (s_srstn),
        .busy          (s_busy),
        .done          (s_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Register files: data valid only in the second cycle after an address change
    int          b_age  = 3;
    logic [5:0]  b_last = '0;
    int          s_age  = 3;
    logic [0:0]  s_last = '0;

    always @(posedge clock) begin
        #1;
        if (b_cfg_addr != b_last) b_age = 0;
        else if (b_age < 3) b_age++;
        b_last = b_cfg_addr;
        if (b_age == 1 || !garbage) b_cfg_data = b_mem[b_cfg_addr];
        else b_cfg_data = 13'($urandom);
        if (s_cfg_addr != s_last) s_age = 0;
        else if (s_age < 3) s_age++;
        s_last = s_cfg_addr;
        if (s_age == 1 || !garbage) s_cfg_data = s_mem[s_cfg_addr];
        else s_cfg_data = 13'($urandom);
    end

    // Chain monitors, sampled on the falling edge
    int           b_busy_n, b_done_n, b_load_n, b_rise_n, b_viol, b_stab;
    logic         b_pclk = 1'b0, b_pdat = 1'b0;
    logic [493:0] b_chain;
    int           s_busy_n, s_rise_n, s_high_n, s_viol, s_stab;
    logic         s_pclk = 1'b0, s_pdat = 1'b0;
    logic [25:0]  s_chain;

    always @(negedge clock) begin
        if (b_busy) b_busy_n++;
        if (b_done) b_done_n++;
        if (b_sload) b_load_n++;
        if (b_sload && b_sclk) b_viol++;
        if (b_sdat != b_pdat) b_stab = 1;
        else b_stab++;
        if (b_sclk && !b_pclk) begin
            b_rise_n++;
            b_chain = {b_chain[492:0], b_sdat};
            if (b_stab <= 2) b_viol++;
        end
        if (b_sclk && b_pclk && b_sdat != b_pdat) b_viol++;
        b_pclk = b_sclk;
        b_pdat = b_sdat;

        if (s_busy) s_busy_n++;
        if (s_sclk) s_high_n++;
        if (s_sload && s_sclk) s_viol++;
        if (s_sdat != s_pdat) s_stab = 1;
        else s_stab++;
        if (s_sclk && !s_pclk) begin
            s_rise_n++;
            s_chain = {s_chain[24:0], s_sdat};
            if (s_stab <= 1) s_viol++;
        end
        s_pclk = s_sclk;
        s_pdat = s_sdat;
    end

    task automatic clr_mon();
        b_busy_n = 0; b_done_n = 0; b_load_n = 0;
        b_rise_n = 0; b_viol = 0; b_chain = '0;
        s_busy_n = 0; s_rise_n = 0; s_high_n = 0;
        s_viol = 0; s_chain = '0;
    endtask

    function automatic int bad_pads();
        int n = 0;
        for (int p = 0; p < 38; p++)
            if (b_chain[p*13 +: 13] !== b_mem[p]) n++;
        return n;
    endfunction

    // Pulse start; returns at +1 of the first busy cycle with monitors cleared
    task automatic start_b();
        @(posedge clock); #1 b_start = 1'b1;
        @(posedge clock); #1 b_start = 1'b0;
        clr_mon();
    endtask

    task automatic wait_b_done(input string tag);
        int n = 0;
        while (b_done !== 1'b1 && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        check(tag, 32'(b_done), 32'd1);
        @(negedge clock); #1;
    endtask

    task automatic check_full(input string tag);
        check({tag, "_busy_len"}, b_busy_n, 2056);
        check({tag, "_rises"}, b_rise_n, 494);
        check({tag, "_load_len"}, b_load_n, 2);
        check({tag, "_dones"}, b_done_n, 1);
        check({tag, "_timing"}, b_viol, 0);
        check({tag, "_chain"}, bad_pads(), 0);
    endtask

    initial begin
        int n;
        resetb  = 1'b0;
        b_start = 1'b0;
        s_start = 1'b0;
        clr_mon();
        for (int p = 0; p < 38; p++) b_mem[p] = 13'h1803;
        s_mem[0] = 13'h1234;
        s_mem[1] = 13'h0ACE;

        // Reset values
        #23;
        check("rst_outs", 32'({b_busy, b_done, b_sclk, b_sdat, b_sload, b_srstn}), 0);
        check("rst_addr", 32'(b_cfg_addr), 0);
        check("rst_small", 32'({s_busy, s_done, s_sclk, s_srstn}), 0);
        @(negedge clock);
        resetb = 1'b1;
        #1 check("srstn_held", 32'(b_srstn), 0);
        @(posedge clock); #1;
        check("srstn_rise", 32'(b_srstn), 1);

        // All words 13'h1803
        start_b();
        check("busy_rise", 32'(b_busy), 1);
        wait_b_done("t1_done");
        check_full("t1");

        // Pad 37 = 13'h1555, rest zero, garbage outside fetch window
        for (int p = 0; p < 38; p++) b_mem[p] = 13'h0;
        b_mem[37] = 13'h1555;
        garbage   = 1'b1;
        start_b();
        wait_b_done("t2_done");
        check("t2_first4", 32'(b_chain[493:490]), 32'hA);
        check("t2_pad37", 32'(b_chain[493:481]), 32'h1555);
        check("t2_rest0", 32'(|b_chain[480:0]), 0);
        check_full("t2");

        // Stray start mid-transfer and in the final load cycle
        for (int p = 0; p < 38; p++) b_mem[p] = 13'(p * 97 + 5);
        start_b();
        repeat (99) begin
            @(posedge clock); #1;
        end
        b_start = 1'b1;
        @(posedge clock); #1 b_start = 1'b0;
        n = 0;
        while (b_sload !== 1'b1 && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        check("t3_load_seen", 32'(b_sload), 1);
        @(posedge clock); #1 b_start = 1'b1;
        @(posedge clock); #1 b_start = 1'b0;
        check("t3_done", 32'(b_done), 1);
        @(negedge clock); #1;
        check_full("t3");
        @(posedge clock); #1;
        check("t3_late_ign", 32'(b_busy), 0);

        // Start during the done cycle begins a new transfer
        start_b();
        n = 0;
        while (b_done !== 1'b1 && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        check("t4_done", 32'(b_done), 1);
        check("t4_busy_len", b_busy_n, 2056);
        b_start = 1'b1;
        @(posedge clock); #1 b_start = 1'b0;
        clr_mon();
        check("t4_restart", 32'(b_busy), 1);
        wait_b_done("t4b_done");
        check_full("t4b");

        // Reset mid-transfer
        start_b();
        repeat (699) begin
            @(posedge clock); #1;
        end
        #2 resetb = 1'b0;
        #1;
        check("t5_async", 32'({b_busy, b_done, b_sclk, b_sdat, b_sload, b_srstn}), 0);
        check("t5_addr", 32'(b_cfg_addr), 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetb = 1'b1;
        #1 check("t5_srstn_held", 32'(b_srstn), 0);
        @(posedge clock); #1;
        check("t5_srstn_rise", 32'(b_srstn), 1);
        check("t5_idle", 32'(b_busy), 0);
        start_b();
        wait_b_done("t5_done");
        check_full("t5");

        // Small chain: NUM_PADS=2, CLK_DIV=1
        @(posedge clock); #1 s_start = 1'b1;
        @(posedge clock); #1 s_start = 1'b0;
        clr_mon();
        n = 0;
        while (s_done !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("s_done", 32'(s_done), 1);
        @(negedge clock); #1;
        check("s_busy_len", s_busy_n, 58);
        check("s_rises", s_rise_n, 26);
        check("s_highs", s_high_n, 26);
        check("s_timing", s_viol, 0);
        check("s_pad1", 32'(s_chain[25:13]), 32'h0ACE);
        check("s_pad0", 32'(s_chain[12:0]), 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, n_fail %0d", n_fail);
        $fatal(1);
    end

endmodule
